program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 31 +++
 rtl/loader_shift_reg.sv | 49 ++++
 rtl/program_loader.sv | 157 +++++++++++++++
 tb/tb_program_loader.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// program_loader_pkg
// Shared widths, default parameter values, load address and FSM state
// encoding for the program loader and its byte-to-word assembler.
package program_loader_pkg;

    localparam int unsigned BYTE_WIDTH                   = 8;
    localparam int unsigned HEADER_WIDTH                 = 16;
    localparam int unsigned ADDRESS_STRIDE               = 4;
    localparam int unsigned DEFAULT_INSTRUCTION_WIDTH    = 32;
    localparam int unsigned DEFAULT_ADDRESS_BUS_WIDTH    = 12;
    localparam int unsigned DEFAULT_PROGRAM_LOAD_ADDRESS = 'h800;
    localparam int unsigned DEFAULT_MAX_WORDS            = 512;

    typedef enum logic [2:0] {
        LEN_HI = 3'd0,
        LEN_LO = 3'd1,
        DATA   = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } loaderState_t;

    // Byte counter width for a word of instructionWidth bits; a single-byte
    // word still gets a one-bit counter so the port never collapses to zero.
    function automatic int unsigned byteCountWidth(input int unsigned instructionWidth);
        int unsigned bytesPerWord;
        bytesPerWord = instructionWidth / BYTE_WIDTH;
        return (bytesPerWord > 1) ? $clog2(bytesPerWord) : 1;
    endfunction

endpackage

// File: rtl/loader_shift_reg.sv
// loader_shift_reg
// Assembles a byte stream into an instruction word, first byte ending up in
// the most significant position, and counts bytes within the current word.
//   mainClock   in   clock
//   reset       in   asynchronous active-high reset
//   shiftEnable in   shift byteIn into the word and advance the byte counter
//   clearCount  in   restart the byte counter for the next word
//   byteIn      in   incoming byte
//   word        out  assembled (registered) word
//   lastByte    out  the next accepted byte completes the word
module loader_shift_reg
    import program_loader_pkg::*;
#(
    parameter int unsigned INSTRUCTION_WIDTH = DEFAULT_INSTRUCTION_WIDTH
) (
    input  logic                         mainClock,
    input  logic                         reset,
    input  logic                         shiftEnable,
    input  logic                         clearCount,
    input  logic [7:0]                   byteIn,
    output logic [INSTRUCTION_WIDTH-1:0] word,
    output logic                         lastByte
);

    localparam int unsigned BYTES_PER_WORD = INSTRUCTION_WIDTH / BYTE_WIDTH;
    localparam int unsigned COUNT_WIDTH    = byteCountWidth(INSTRUCTION_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] LAST_INDEX = COUNT_WIDTH'(BYTES_PER_WORD - 1);

    logic [COUNT_WIDTH-1:0] byteCount;

    always_ff @(posedge mainClock or posedge reset) begin
        if (reset) begin
            word      <= '0;
            byteCount <= '0;
        end else begin
            if (shiftEnable) begin
                word <= (word << BYTE_WIDTH) | INSTRUCTION_WIDTH'(byteIn);
            end
            if (clearCount) begin
                byteCount <= '0;
            end else if (shiftEnable) begin
                byteCount <= byteCount + COUNT_WIDTH'(1);
            end
        end
    end

    assign lastByte = (byteCount == LAST_INDEX);

endmodule

// File: rtl/program_loader.sv
// program_loader
// Receives a program over a byte stream (16-bit big-endian word count, then
// the words MSB first), writes each word to instruction RAM and holds the CPU
// in reset until the whole program has been written.
//   mainClock  in   clock
//   reset      in   asynchronous active-high reset
//   restart    in   begin a new load from DONE or ERROR
//   rxData     in   program byte
//   rxValid    in   rxData valid
//   rxReady    out  a byte is accepted this cycle if rxValid is high
//   ramAddress out  instruction RAM byte address
//   ramData    out  assembled instruction word
//   ramWrite   out  single-cycle RAM write strobe
//   cpuReset   out  CPU held in reset
//   loadDone   out  program completely written (sticky)
//   loadError  out  header rejected (sticky)
//
// state  | meaning
// LEN_HI | waiting for word-count high byte
// LEN_LO | waiting for word-count low byte, then range check
// DATA   | collecting bytes of the current word
// WRITE  | one-cycle RAM write of the assembled word
// DONE   | program loaded, CPU released
// ERROR  | word count out of range, CPU kept in reset
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned                  INSTRUCTION_WIDTH    = DEFAULT_INSTRUCTION_WIDTH,
    parameter int unsigned                  ADDRESS_BUS_WIDTH    = DEFAULT_ADDRESS_BUS_WIDTH,
    parameter logic [ADDRESS_BUS_WIDTH-1:0] PROGRAM_LOAD_ADDRESS = ADDRESS_BUS_WIDTH'(DEFAULT_PROGRAM_LOAD_ADDRESS),
    parameter int unsigned                  MAX_WORDS            = DEFAULT_MAX_WORDS
) (
    input  logic                         mainClock,
    input  logic                         reset,
    input  logic                         restart,
    input  logic [7:0]                   rxData,
    input  logic                         rxValid,
    output logic                         rxReady,
    output logic [ADDRESS_BUS_WIDTH-1:0] ramAddress,
    output logic [INSTRUCTION_WIDTH-1:0] ramData,
    output logic                         ramWrite,
    output logic                         cpuReset,
    output logic                         loadDone,
    output logic                         loadError
);

    loaderState_t            state;
    loaderState_t            nextState;
    logic [7:0]              headerHigh;
    logic [HEADER_WIDTH-1:0] headerCount;
    logic [HEADER_WIDTH-1:0] wordsLeft;
    logic                    byteAccepted;
    logic                    restartAccepted;
    logic                    wordLast;
    logic                    ramWriteNext;
    logic                    cpuResetNext;
    logic                    loadDoneNext;
    logic                    loadErrorNext;

    // Ready is the only output not taken straight from a flop: gating it with
    // reset keeps it low during reset while still allowing a byte on the very
    // first edge after reset is released.
    assign rxReady = !reset && ((state == LEN_HI) || (state == LEN_LO) || (state == DATA));

    assign byteAccepted    = rxValid && rxReady;
    assign restartAccepted = restart && ((state == DONE) || (state == ERROR));
    assign headerCount     = {headerHigh, rxData};

    always_ff @(posedge mainClock or posedge reset) begin
        if (reset) begin
            state     <= LEN_HI;
            ramWrite  <= 1'b0;
            cpuReset  <= 1'b1;
            loadDone  <= 1'b0;
            loadError <= 1'b0;
        end else begin
            state     <= nextState;
            ramWrite  <= ramWriteNext;
            cpuReset  <= cpuResetNext;
            loadDone  <= loadDoneNext;
            loadError <= loadErrorNext;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            LEN_HI: begin
                if (byteAccepted) nextState = LEN_LO;
            end
            LEN_LO: begin
                if (byteAccepted) begin
                    if (headerCount == '0) begin
                        nextState = DONE;
                    end else if (32'(headerCount) > MAX_WORDS) begin
                        nextState = ERROR;
                    end else begin
                        nextState = DATA;
                    end
                end
            end
            DATA: begin
                if (byteAccepted && wordLast) nextState = WRITE;
            end
            WRITE: begin
                // terminal compare before the decrement lands
                nextState = (wordsLeft == HEADER_WIDTH'(1)) ? DONE : DATA;
            end
            DONE, ERROR: begin
                if (restart) nextState = LEN_HI;
            end
            default: nextState = LEN_HI;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change
    // in the same cycle the state register does.
    always_comb begin
        ramWriteNext  = (nextState == WRITE);
        cpuResetNext  = (nextState != DONE);
        loadDoneNext  = (nextState == DONE);
        loadErrorNext = (nextState == ERROR);
    end

    always_ff @(posedge mainClock or posedge reset) begin
        if (reset) begin
            headerHigh <= '0;
            wordsLeft  <= '0;
            ramAddress <= PROGRAM_LOAD_ADDRESS;
        end else begin
            if ((state == LEN_HI) && byteAccepted) begin
                headerHigh <= rxData;
            end
            if ((state == LEN_LO) && byteAccepted) begin
                wordsLeft  <= headerCount;
                ramAddress <= PROGRAM_LOAD_ADDRESS;
            end
            if (state == WRITE) begin
                wordsLeft  <= wordsLeft - HEADER_WIDTH'(1);
                ramAddress <= ramAddress + ADDRESS_BUS_WIDTH'(ADDRESS_STRIDE);
            end
        end
    end

    loader_shift_reg #(
        .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH)
    ) shiftReg (
        .mainClock   (mainClock),
        .reset       (reset),
        .shiftEnable ((state == DATA) && byteAccepted),
        .clearCount  ((state == WRITE) || restartAccepted),
        .byteIn      (rxData),
        .word        (ramData),
        .lastByte    (wordLast)
    );

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    localparam int LOAD_ADDR = 'h800;
    localparam int MAX_W     = 512;

    logic        mainClock;
    logic        reset;
    logic        restart;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        rxReady;
    logic [11:0] ramAddress;
    logic [31:0] ramData;
    logic        ramWrite;
    logic        cpuReset;
    logic        loadDone;
    logic        loadError;

    program_loader dut (
        .mainClock  (mainClock),
        .reset      (reset),
        .restart    (restart),
        .rxData     (rxData),
        .rxValid    (rxValid),
        .rxReady    (rxReady),
        .ramAddress (ramAddress),
        .ramData    (ramData),
        .ramWrite   (ramWrite),
        .cpuReset   (cpuReset),
        .loadDone   (loadDone),
        .loadError  (loadError)
    );

    initial mainClock = 1'b0;
    always #5 mainClock = ~mainClock;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } writeRec_t;

    typedef struct {
        logic [7:0] lenHi;
        logic [7:0] lenLo;
        int         words;
        logic       expDone;
        logic       expError;
        int         expWrites;
    } vector_t;

    int         checks = 0;
    int         errors = 0;
    writeRec_t  captured[$];
    writeRec_t  expectedQ[$];
    logic [7:0] streamQ[$];
    logic       modelDone;
    logic       modelError;
    writeRec_t  firstWrite;
    vector_t    vectors[6];

    always @(negedge mainClock) begin
        if (ramWrite === 1'b1) captured.push_back({ramAddress, ramData});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Reference: the word count selects done/error; each complete group of
    // four bytes after the header is one write at load address + 4*index.
    function automatic void modelLoad();
        int n;
        expectedQ.delete();
        n = int'({streamQ[0], streamQ[1]});
        modelError = (n > MAX_W);
        modelDone  = !modelError && (streamQ.size() >= 2 + 4 * n);
        if (!modelError) begin
            for (int i = 0; i < n; i++) begin
                if (2 + 4 * i + 3 < streamQ.size()) begin
                    expectedQ.push_back({12'((LOAD_ADDR + 4 * i) % 4096),
                                         streamQ[2+4*i], streamQ[3+4*i],
                                         streamQ[4+4*i], streamQ[5+4*i]});
                end
            end
        end
    endfunction

    task automatic makeStream(input logic [15:0] n, input int words);
        streamQ.delete();
        streamQ.push_back(n[15:8]);
        streamQ.push_back(n[7:0]);
        for (int i = 0; i < 4 * words; i++) streamQ.push_back(8'($urandom));
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic sendByte(input logic [7:0] b, input int gap);
        int budget;
        budget = 0;
        repeat (gap) @(negedge mainClock);
        while (rxReady !== 1'b1 && budget < 200) begin
            @(negedge mainClock);
            budget++;
        end
        if (rxReady !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL sendByte timeout rxReady=%b required=1", rxReady);
        end else begin
            rxValid = 1'b1;
            rxData  = b;
            @(negedge mainClock);
            rxValid = 1'b0;
            rxData  = 8'($urandom);
        end
    endtask

    task automatic finishCheck(input string name);
        repeat (3) @(negedge mainClock);
        check({name, " loadDone"},  64'(loadDone),  64'(modelDone));
        check({name, " loadError"}, 64'(loadError), 64'(modelError));
        check({name, " cpuReset"},  64'(cpuReset),  64'(!modelDone));
        check({name, " rxReady"},   64'(rxReady),   64'(!(modelDone || modelError)));
        check({name, " writeCount"}, 64'(captured.size()), 64'(expectedQ.size()));
        for (int i = 0; i < captured.size() && i < expectedQ.size(); i++) begin
            check({name, " write"}, 64'(captured[i]), 64'(expectedQ[i]));
        end
    endtask

    task automatic runStream(input int gapMin, input int gapMax, input string name);
        captured.delete();
        modelLoad();
        foreach (streamQ[i]) sendByte(streamQ[i], $urandom_range(gapMax, gapMin));
        finishCheck(name);
    endtask

    task automatic doRestart();
        @(negedge mainClock);
        restart = 1'b1;
        @(negedge mainClock);
        restart = 1'b0;
        check("restart loadDone",  64'(loadDone),  64'(0));
        check("restart loadError", 64'(loadError), 64'(0));
        check("restart cpuReset",  64'(cpuReset),  64'(1));
        check("restart rxReady",   64'(rxReady),   64'(1));
    endtask

    initial begin
        reset   = 1'b1;
        restart = 1'b0;
        rxValid = 1'b0;
        rxData  = 8'h00;

        vectors[0] = '{8'h00, 8'h00, 0,   1'b1, 1'b0, 0};
        vectors[1] = '{8'h02, 8'h01, 0,   1'b0, 1'b1, 0};
        vectors[2] = '{8'hFF, 8'hFF, 0,   1'b0, 1'b1, 0};
        vectors[3] = '{8'h00, 8'h01, 1,   1'b1, 1'b0, 1};
        vectors[4] = '{8'h00, 8'h05, 5,   1'b1, 1'b0, 5};
        vectors[5] = '{8'h02, 8'h00, 512, 1'b1, 1'b0, 512};

        // reset values
        repeat (2) @(negedge mainClock);
        check("reset rxReady",    64'(rxReady),    64'(0));
        check("reset ramWrite",   64'(ramWrite),   64'(0));
        check("reset ramAddress", 64'(ramAddress), 64'(LOAD_ADDR));
        check("reset ramData",    64'(ramData),    64'(0));
        check("reset cpuReset",   64'(cpuReset),   64'(1));
        check("reset loadDone",   64'(loadDone),   64'(0));
        check("reset loadError",  64'(loadError),  64'(0));
        reset = 1'b0;
        #1;
        check("post-reset rxReady", 64'(rxReady), 64'(1));

        // empty program: done right after the second header byte
        captured.delete();
        sendByte(8'h00, 0);
        sendByte(8'h00, 0);
        check("empty loadDone", 64'(loadDone), 64'(1));
        check("empty cpuReset", 64'(cpuReset), 64'(0));
        repeat (3) @(negedge mainClock);
        check("empty writes", 64'(captured.size()), 64'(0));
        doRestart();

        // two-word reference program
        streamQ = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        runStream(0, 0, "twoWord");
        if (captured.size() == 2) begin
            check("twoWord first",  64'(captured[0]), {20'h0, 12'h800, 32'h11223344});
            check("twoWord second", 64'(captured[1]), {20'h0, 12'h804, 32'hAABBCCDD});
        end
        doRestart();

        // oversize header 513
        streamQ = '{8'h02, 8'h01};
        runStream(0, 0, "oversize");
        check("oversize loadError", 64'(loadError), 64'(1));
        doRestart();

        // table-driven headers
        for (int v = 0; v < 6; v++) begin
            makeStream({vectors[v].lenHi, vectors[v].lenLo}, vectors[v].words);
            runStream(0, (vectors[v].words > 16) ? 0 : 1, "table");
            check("table vecDone",   64'(loadDone),         64'(vectors[v].expDone));
            check("table vecError",  64'(loadError),        64'(vectors[v].expError));
            check("table vecWrites", 64'(captured.size()),  64'(vectors[v].expWrites));
            if (vectors[v].expWrites == 512 && captured.size() == 512) begin
                check("table lastAddr", 64'(captured[511].addr), 64'(12'hFFC));
            end
            doRestart();
        end

        // continuous versus toggled rxValid within one word
        streamQ = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        runStream(0, 0, "continuous");
        firstWrite = (captured.size() > 0) ? captured[0] : '0;
        doRestart();
        runStream(1, 1, "toggled");
        check("toggled pulses", 64'(captured.size()), 64'(1));
        if (captured.size() > 0) check("toggled same write", 64'(captured[0]), 64'(firstWrite));
        doRestart();

        // restart ignored mid-word, long stall retains partial word
        makeStream(16'd2, 2);
        captured.delete();
        modelLoad();
        for (int i = 0; i < 4; i++) sendByte(streamQ[i], 0);
        restart = 1'b1;
        @(negedge mainClock);
        restart = 1'b0;
        check("midRestart rxReady",  64'(rxReady),  64'(1));
        check("midRestart loadDone", 64'(loadDone), 64'(0));
        repeat (20) @(negedge mainClock);
        check("stall writes",   64'(captured.size()), 64'(0));
        check("stall cpuReset", 64'(cpuReset),        64'(1));
        for (int i = 4; i < streamQ.size(); i++) sendByte(streamQ[i], 0);
        finishCheck("stall");
        doRestart();

        // reset after two bytes of the first word
        makeStream(16'd1, 1);
        captured.delete();
        for (int i = 0; i < 4; i++) sendByte(streamQ[i], 0);
        reset = 1'b1;
        #1;
        check("midReset rxReady",    64'(rxReady),    64'(0));
        check("midReset ramAddress", 64'(ramAddress), 64'(LOAD_ADDR));
        check("midReset ramData",    64'(ramData),    64'(0));
        check("midReset cpuReset",   64'(cpuReset),   64'(1));
        check("midReset loadDone",   64'(loadDone),   64'(0));
        repeat (2) @(negedge mainClock);
        reset = 1'b0;
        #1;
        check("midReset ready after", 64'(rxReady), 64'(1));
        repeat (3) @(negedge mainClock);
        check("midReset writes", 64'(captured.size()), 64'(0));
        makeStream(16'd1, 1);
        runStream(0, 0, "afterReset");
        if (captured.size() == 1) check("afterReset addr", 64'(captured[0].addr), 64'(12'h800));
        doRestart();

        // randomized loads against the reference model
        for (int it = 0; it < 12; it++) begin
            int r;
            int n;
            r = $urandom_range(9, 0);
            if (r == 0)      n = 0;
            else if (r == 1) n = $urandom_range(700, 513);
            else             n = $urandom_range(12, 1);
            makeStream(16'(n), (n > MAX_W) ? 0 : n);
            runStream(0, 2, "random");
            doRestart();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
